// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared definitions for the EN/RW/MFC memory bus master:
//                state encoding, RW encoding and default bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    // Default bus widths
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // RW encoding shared by the control unit and the memory
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Bus master state encoding
    localparam int       ST_W       = 2;
    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_SETUP   = 2'd1;
    localparam logic [ST_W-1:0] ST_ASSERT  = 2'd2;
    localparam logic [ST_W-1:0] ST_RELEASE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
//  Module      : sync_bit
//  Description : N-flop synchroniser for a single asynchronous input bit,
//                asynchronous active-low reset clears every stage to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_master
//  Description : CPU-side initiator for the four-phase EN/RW/MFC memory
//                handshake. Accepts one read or write request at a time,
//                drives the memory, waits for MFC, then pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SETUP_CYC   = 1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_EN,
    output logic              mem_RW,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_MFC
);

    localparam int SU_W = (SETUP_CYC > 0) ? $clog2(SETUP_CYC + 1) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    // SETUP ends when the counter has accumulated SETUP_CYC hold cycles
    localparam logic [SU_W-1:0] c_SETUP_LAST = SU_W'(SETUP_CYC);
    // Counter value in the TIMEOUT-th cycle spent in ASSERT or RELEASE
    localparam logic [TO_W-1:0] c_TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] c_TO_MAX     = TO_W'(TIMEOUT);

    logic              w_mfc_s;

    logic [ST_W-1:0]   r_state,     w_state_nxt;
    logic [SU_W-1:0]   r_setup_cnt, w_setup_nxt;
    logic [TO_W-1:0]   r_to_cnt,    w_to_nxt;
    logic              r_err_flag,  w_err_flag_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_err,       w_err_nxt;
    logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;
    logic              r_en,        w_en_nxt;
    logic              r_rw,        w_rw_nxt;
    logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
    logic [DATA_W-1:0] r_wdata,     w_wdata_nxt;
    logic [TO_W-1:0]   w_to_inc;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_mfc_sync (
        .clk   (Clock),
        .rst_n (Resetn),
        .i_d   (mem_MFC),
        .o_q   (w_mfc_s)
    );

    // Saturating increment of the timeout counter
    assign w_to_inc = (r_to_cnt == c_TO_MAX) ? r_to_cnt : r_to_cnt + 1'b1;

    // Next-state and next-output logic of the handshake sequencer
    always_comb begin
        w_state_nxt    = r_state;
        w_setup_nxt    = r_setup_cnt;
        w_to_nxt       = r_to_cnt;
        w_err_flag_nxt = r_err_flag;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_rdata_nxt    = r_rdata;
        w_en_nxt       = r_en;
        w_rw_nxt       = r_rw;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;

        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_rw_nxt       = cpu_rw;
                    w_addr_nxt     = cpu_addr;
                    w_wdata_nxt    = cpu_wdata;
                    w_setup_nxt    = '0;
                    w_err_flag_nxt = 1'b0;
                    w_state_nxt    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Address, RW and data are already stable; MFC is ignored here
                if (r_setup_cnt == c_SETUP_LAST) begin
                    w_en_nxt    = 1'b1;
                    w_to_nxt    = '0;
                    w_state_nxt = ST_ASSERT;
                end else begin
                    w_setup_nxt = r_setup_cnt + 1'b1;
                end
            end
            ST_ASSERT: begin
                if (w_mfc_s) begin
                    w_en_nxt = 1'b0;
                    if (r_rw == RW_READ) begin
                        w_rdata_nxt = mem_rdata;
                    end
                    w_to_nxt    = '0;
                    w_state_nxt = ST_RELEASE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_en_nxt       = 1'b0;
                    w_err_flag_nxt = 1'b1;
                    w_to_nxt       = '0;
                    w_state_nxt    = ST_RELEASE;
                end else begin
                    w_to_nxt = w_to_inc;
                end
            end
            ST_RELEASE: begin
                if (!w_mfc_s) begin
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = r_err_flag;
                    w_state_nxt = ST_IDLE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_to_nxt = w_to_inc;
                end
            end
            default: begin
                w_en_nxt    = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, counters and registered outputs; reset drops EN immediately
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state     <= ST_IDLE;
            r_setup_cnt <= '0;
            r_to_cnt    <= '0;
            r_err_flag  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_en        <= 1'b0;
            r_rw        <= RW_READ;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_setup_cnt <= w_setup_nxt;
            r_to_cnt    <= w_to_nxt;
            r_err_flag  <= w_err_flag_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_rdata     <= w_rdata_nxt;
            r_en        <= w_en_nxt;
            r_rw        <= w_rw_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_EN    = r_en;
    assign mem_RW    = r_rw;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_master
//  Description : Self-checking bench for mem_bus_master with a behavioural
//                four-phase memory responder and a done-driven scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_bus_master;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        req = 1'b0;
    logic        cpu_rw = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        busy, done, err;
    logic [15:0] rdata;
    logic        mem_EN, mem_RW;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_MFC = 1'b0;

    mem_bus_master #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .SETUP_CYC   (1),
        .SYNC_STAGES (2),
        .TIMEOUT     (255)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .req       (req),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_EN    (mem_EN),
        .mem_RW    (mem_RW),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_MFC   (mem_MFC)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural memory responder ----------------
    logic [15:0] mem [0:255];
    bit          mfc_dead = 1'b0;
    logic        exp_rw = 1'b1;
    logic [15:0] exp_addr = '0;
    logic [15:0] exp_wdata = '0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
    end

    always @(posedge mem_EN) begin
        #1;
        if (mem_RW) mem_rdata = mem[mem_addr[7:0]];
        else        mem[mem_addr[7:0]] = mem_wdata;
        #2;
        if (mem_EN && !mfc_dead) mem_MFC = 1'b1;
    end

    always @(negedge mem_EN) begin
        #1 mem_MFC = 1'b0;
    end

    // Bus fields must be correct at the EN rise and unchanged at its fall
    always @(posedge mem_EN) begin
        check("en_rise_addr", {16'h0, mem_addr}, {16'h0, exp_addr});
        check("en_rise_rw", {31'h0, mem_RW}, {31'h0, exp_rw});
        if (exp_rw == 1'b0) check("en_rise_wdata", {16'h0, mem_wdata}, {16'h0, exp_wdata});
    end

    always @(negedge mem_EN) begin
        if (Resetn) begin
            check("en_fall_addr", {16'h0, mem_addr}, {16'h0, exp_addr});
            check("en_fall_rw", {31'h0, mem_RW}, {31'h0, exp_rw});
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } exp_t;
    exp_t q[$];

    always @(negedge Clock) begin
        if (Resetn && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_rdata", {16'h0, rdata}, {16'h0, e.rdata});
                check("done_err", {31'h0, err}, {31'h0, e.err});
            end
        end
        if (Resetn && err && !done) check("err_without_done", 32'd1, 32'd0);
    end

    // ---------------- stimulus helpers ----------------
    // Counts edges after the sampling edge until done is seen
    task automatic wait_done(input bit pulse_ign, input logic [15:0] keep_addr,
                             output int cyc, output int en_cnt, output int rise);
        bit got;
        got = 1'b0; cyc = 0; en_cnt = 0; rise = -1;
        while (cyc < 400 && !got) begin
            @(posedge Clock);
            cyc++;
            #1;
            if (mem_EN) begin
                en_cnt++;
                if (rise < 0) rise = cyc;
            end
            if (pulse_ign && cyc == 3) begin
                req = 1'b1; cpu_addr = 16'h0055; cpu_rw = ~cpu_rw;
            end
            if (pulse_ign && cyc == 4) begin
                req = 1'b0;
                check("ign_addr", {16'h0, mem_addr}, {16'h0, keep_addr});
            end
            if (done) got = 1'b1;
        end
    endtask

    task automatic do_req(input string tag, input logic rw, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] exp_rd,
                          input logic exp_err, input int exp_lat, input int exp_en,
                          input bit pulse_ign);
        int cyc, en_cnt, rise;
        exp_t e;
        e = {exp_rd, exp_err};
        q.push_back(e);
        exp_rw = rw; exp_addr = a; exp_wdata = wd;
        @(negedge Clock);
        req = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd;
        @(posedge Clock);
        #1;
        req = 1'b0;
        check({tag, "_busy"}, {31'h0, busy}, 32'd1);
        wait_done(pulse_ign, a, cyc, en_cnt, rise);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_en_cycles"}, en_cnt, exp_en);
        check({tag, "_en_rise"}, rise, 32'd2);
    endtask

    initial begin
        int cyc, en_cnt, rise;
        exp_t e;

        // Reset state
        repeat (2) @(posedge Clock);
        #1;
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_err", {31'h0, err}, 32'd0);
        check("rst_en", {31'h0, mem_EN}, 32'd0);
        check("rst_rw", {31'h0, mem_RW}, 32'd1);
        check("rst_addr", {16'h0, mem_addr}, 32'd0);
        check("rst_wdata", {16'h0, mem_wdata}, 32'd0);
        check("rst_rdata", {16'h0, rdata}, 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (2) @(posedge Clock);

        // Write then read back
        do_req("wr20", 1'b0, 16'h0020, 16'hBEEF, 16'h0000, 1'b0, 8, 3, 1'b0);
        do_req("rd20", 1'b1, 16'h0020, 16'h0000, 16'hBEEF, 1'b0, 8, 3, 1'b0);
        do_req("wr10", 1'b0, 16'h0010, 16'h1234, 16'hBEEF, 1'b0, 8, 3, 1'b0);
        check("mem10", {16'h0, mem[16]}, 32'h1234);

        // Back-to-back with req held high: write 0x30 then read 0x10
        e = {16'hBEEF, 1'b0}; q.push_back(e);
        e = {16'h1234, 1'b0}; q.push_back(e);
        exp_rw = 1'b0; exp_addr = 16'h0030; exp_wdata = 16'hA5A5;
        @(negedge Clock);
        req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0030; cpu_wdata = 16'hA5A5;
        @(posedge Clock);
        #1;
        cpu_rw = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h0000;
        wait_done(1'b0, 16'h0, cyc, en_cnt, rise);
        check("b2b_first_latency", cyc, 32'd8);
        check("b2b_busy_gap", {31'h0, busy}, 32'd0);
        exp_rw = 1'b1; exp_addr = 16'h0010;
        @(posedge Clock);
        #1;
        check("b2b_busy_again", {31'h0, busy}, 32'd1);
        check("b2b_second_addr", {16'h0, mem_addr}, 32'h0010);
        req = 1'b0;
        wait_done(1'b0, 16'h0, cyc, en_cnt, rise);
        check("b2b_second_latency", cyc, 32'd8);
        check("mem30", {16'h0, mem[48]}, 32'hA5A5);

        // Ignored req mid-transaction
        do_req("ign", 1'b1, 16'h0030, 16'h0000, 16'hA5A5, 1'b0, 8, 3, 1'b1);
        repeat (12) @(posedge Clock);

        // Timeout: responder never raises MFC
        mfc_dead = 1'b1;
        do_req("tmo", 1'b1, 16'h0020, 16'h0000, 16'hA5A5, 1'b1, 258, 255, 1'b0);
        mfc_dead = 1'b0;
        repeat (4) @(posedge Clock);

        // Reset while in ASSERT
        exp_rw = 1'b1; exp_addr = 16'h0020;
        @(negedge Clock);
        req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0020;
        @(posedge Clock);
        #1;
        req = 1'b0;
        repeat (3) @(posedge Clock);
        #3;
        check("mid_en_high", {31'h0, mem_EN}, 32'd1);
        Resetn = 1'b0;
        #1;
        check("mid_rst_en", {31'h0, mem_EN}, 32'd0);
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        check("mid_rst_rw", {31'h0, mem_RW}, 32'd1);
        check("mid_rst_addr", {16'h0, mem_addr}, 32'd0);
        check("mid_rst_rdata", {16'h0, rdata}, 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (2) @(posedge Clock);
        do_req("post_rst", 1'b1, 16'h0020, 16'h0000, 16'hBEEF, 1'b0, 8, 3, 1'b0);

        repeat (5) @(posedge Clock);
        check("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
